// File: rtl/input_event_queue_if.sv
// -----------------------------------------------------------------------------
// input_event_queue_if
//
// Purpose: bundles the CPU-facing and keyboard-facing signals of the input
// event queue. The master side (CPU / keyboard decoder) drives the strobes, and
// the slave side (the queue) returns the status word and the flags.
//
// Signals:
//   kb_valid  master->slave  one-cycle strobe, kb_code is valid
//   kb_code   master->slave  8-bit keyboard scan code
//   rd_en     master->slave  pop strobe (I/O-address read this cycle)
//   clr_ovf   master->slave  clears the sticky overflow flag
//   rd_data   slave->master  status word and head event (WIDTH bits)
//   empty     slave->master  queue holds no entries
//   full      slave->master  queue holds DEPTH entries
//   overflow  slave->master  sticky, a keyboard code was dropped
// -----------------------------------------------------------------------------
interface input_event_queue_if #(
    parameter int WIDTH = 16
);
    logic             kb_valid;
    logic [7:0]       kb_code;
    logic             rd_en;
    logic             clr_ovf;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             overflow;

    modport master (
        output kb_valid, kb_code, rd_en, clr_ovf,
        input  rd_data, empty, full, overflow
    );

    modport slave (
        input  kb_valid, kb_code, rd_en, clr_ovf,
        output rd_data, empty, full, overflow
    );
endinterface

// File: rtl/input_event_queue.sv
// -----------------------------------------------------------------------------
// input_event_queue
//
// Purpose: debounces the three active-low push buttons, turns each press into
// a one-shot scan code (left / right / shoot) and merges these codes with
// keyboard scan-code strobes into a first-word-fall-through FIFO that the CPU
// reads and pops one event at a time.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         synchronous, active-low reset
//   left_button   raw asynchronous button, active-low
//   right_button  raw asynchronous button, active-low
//   shoot_button  raw asynchronous button, active-low
//   bus           input_event_queue_if.slave: kb_valid, kb_code, rd_en,
//                 clr_ovf in; rd_data, empty, full, overflow out
//
// rd_data layout: [15] ~empty, [14:12] held {shoot,right,left},
//                 [11:8] zero, [7:0] head entry (zero when empty).
// -----------------------------------------------------------------------------
module input_event_queue #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int DB_CYCLES  = 500000,
    parameter int LEFT_CODE  = 28,
    parameter int RIGHT_CODE = 35,
    parameter int SHOOT_CODE = 41
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 left_button,
    input  logic                 right_button,
    input  logic                 shoot_button,
    input_event_queue_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DB_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [7:0]    LEFT_C   = 8'(LEFT_CODE);
    localparam logic [7:0]    RIGHT_C  = 8'(RIGHT_CODE);
    localparam logic [7:0]    SHOOT_C  = 8'(SHOOT_CODE);

    // Button vectors are indexed 0 = left, 1 = right, 2 = shoot.
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    db;
    logic [2:0]    db_d;
    logic [2:0]    pend;
    logic [2:0]    press;
    logic [2:0]    held;
    logic [CW-1:0] cnt [3];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovf;

    logic          empty_i;
    logic          full_i;
    logic          pop;
    logic          space;
    logic          kb_wr;
    logic          drop;
    logic          btn_ok;
    logic [2:0]    btn_wr;
    logic          push;
    logic [7:0]    wr_code;
    logic [7:0]    head;
    logic [15:0]   status;

    assign raw   = {shoot_button, right_button, left_button};
    assign press = db_d & ~db;   // debounced level just fell: a new press
    assign held  = ~db;

    // -------------------------------------------------------------------------
    // Synchronizers, debouncers and pending flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1   <= '1;
            s2   <= '1;
            db   <= '1;
            db_d <= '1;
            pend <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_d <= db;
            // A press that arrives on the same edge a write retires the old
            // flag keeps the flag set.
            pend <= (pend & ~btn_wr) | press;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write arbitration: keyboard first, then left > right > shoot
    // -------------------------------------------------------------------------
    assign empty_i = (count == '0);
    assign full_i  = (count == FULL_CNT);
    assign pop     = bus.rd_en & ~empty_i;
    // A pop on the same edge frees the slot the push needs.
    assign space   = ~full_i | pop;
    assign kb_wr   = bus.kb_valid & space;
    assign drop    = bus.kb_valid & ~space;
    assign btn_ok  = ~bus.kb_valid & space;

    always_comb begin
        btn_wr  = '0;
        wr_code = bus.kb_code;
        if (!kb_wr && btn_ok) begin
            if (pend[0]) begin
                btn_wr  = 3'b001;
                wr_code = LEFT_C;
            end else if (pend[1]) begin
                btn_wr  = 3'b010;
                wr_code = RIGHT_C;
            end else if (pend[2]) begin
                btn_wr  = 3'b100;
                wr_code = SHOOT_C;
            end
        end
    end

    assign push = kb_wr | (|btn_wr);

    // -------------------------------------------------------------------------
    // FIFO storage (data only, no reset needed: reads are gated by empty)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_code;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers, occupancy and sticky overflow
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // A drop on the same edge as a clear leaves the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status word (FWFT head, combinational from state only)
    // -------------------------------------------------------------------------
    assign head   = empty_i ? 8'h00 : mem[rd_ptr];
    assign status = {~empty_i, held, 4'b0000, head};

    assign bus.rd_data  = WIDTH'(status);
    assign bus.empty    = empty_i;
    assign bus.full     = full_i;
    assign bus.overflow = ovf;

endmodule

// File: tb/tb_input_event_queue.sv
// -----------------------------------------------------------------------------
// tb_input_event_queue
//
// Directed bench for input_event_queue with DEPTH=4 and DB_CYCLES=4. Inputs
// change 1 ns after a rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_input_event_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DBC   = 4;

    logic clk          = 1'b0;
    logic reset        = 1'b0;
    logic left_button  = 1'b1;
    logic right_button = 1'b1;
    logic shoot_button = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    input_event_queue_if #(.WIDTH(WIDTH)) bus ();

    input_event_queue #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .DB_CYCLES  (DBC),
        .LEFT_CODE  (28),
        .RIGHT_CODE (35),
        .SHOOT_CODE (41)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .left_button  (left_button),
        .right_button (right_button),
        .shoot_button (shoot_button),
        .bus          (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kb_push(input logic [7:0] code);
        bus.kb_valid = 1'b1;
        bus.kb_code  = code;
        tick();
        bus.kb_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    logic [7:0] exp_codes [4];

    initial begin
        bus.kb_valid = 1'b0;
        bus.kb_code  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.clr_ovf  = 1'b0;

        // Reset and idle
        tick(2);
        reset = 1'b1;
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_rd_data", bus.rd_data, 16'h0000);
        pop_one();
        check("idle_pop_empty", bus.empty, 1'b1);
        check("idle_pop_rd_data", bus.rd_data, 16'h0000);

        // Left press: low just before edge 0, entry written at edge 7
        left_button = 1'b0;
        tick(7);
        check("left_edge6", bus.rd_data, 16'h1000);
        tick();
        check("left_edge7", bus.rd_data, 16'h901C);
        pop_one();
        check("left_pop_held", bus.rd_data, 16'h1000);
        left_button = 1'b1;
        tick(10);
        check("left_release", bus.rd_data, 16'h0000);

        // Shoot bounce never settles long enough
        for (int r = 0; r < 4; r++) begin
            shoot_button = 1'b0;
            tick(3);
            shoot_button = 1'b1;
            tick(2);
        end
        tick(8);
        check("bounce_empty", bus.empty, 1'b1);
        check("bounce_rd_data", bus.rd_data, 16'h0000);
        shoot_button = 1'b0;
        tick(10);
        check("shoot_held", bus.rd_data, 16'hC029);
        shoot_button = 1'b1;
        tick(10);
        check("shoot_released", bus.rd_data, 16'h8029);
        pop_one();
        check("shoot_single", bus.empty, 1'b1);

        // Keyboard beats pending left and right on the same cycle
        left_button  = 1'b0;
        right_button = 1'b0;
        tick(7);
        check("lr_pending", bus.rd_data, 16'h3000);
        kb_push(8'h1D);
        check("kb_first", bus.rd_data, 16'hB01D);
        tick(2);
        check("three_not_full", bus.full, 1'b0);
        check("order0", bus.rd_data[7:0], 8'h1D);
        pop_one();
        check("order1", bus.rd_data[7:0], 8'h1C);
        pop_one();
        check("order2", bus.rd_data[7:0], 8'h23);
        pop_one();
        check("order_empty", bus.rd_data, 16'h3000);
        left_button  = 1'b1;
        right_button = 1'b1;
        tick(10);
        check("lr_release", bus.rd_data, 16'h0000);

        // Fill, overflow, clear, push+pop while full
        kb_push(8'h11);
        check("kb_latency", bus.rd_data, 16'h8011);
        kb_push(8'h12);
        kb_push(8'h13);
        kb_push(8'h14);
        check("full_after4", bus.full, 1'b1);
        check("no_ovf_yet", bus.overflow, 1'b0);
        kb_push(8'h15);
        check("ovf_on5", bus.overflow, 1'b1);
        check("head_kept", bus.rd_data, 16'h8011);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", bus.overflow, 1'b0);
        bus.rd_en = 1'b1;
        kb_push(8'h16);
        bus.rd_en = 1'b0;
        check("pushpop_full", bus.full, 1'b1);
        check("pushpop_head", bus.rd_data, 16'h8012);
        check("pushpop_no_ovf", bus.overflow, 1'b0);
        bus.clr_ovf = 1'b1;
        kb_push(8'h17);
        bus.clr_ovf = 1'b0;
        check("drop_beats_clr", bus.overflow, 1'b1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared2", bus.overflow, 1'b0);
        exp_codes[0] = 8'h12;
        exp_codes[1] = 8'h13;
        exp_codes[2] = 8'h14;
        exp_codes[3] = 8'h16;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d", k), bus.rd_data, {8'h80, exp_codes[k]});
            pop_one();
        end
        check("drain_empty", bus.empty, 1'b1);

        // Reset with three queued entries and right pending
        kb_push(8'h31);
        kb_push(8'h32);
        kb_push(8'h33);
        right_button = 1'b0;
        tick(7);
        check("pre_reset_head", bus.rd_data, 16'hA031);
        reset        = 1'b0;
        right_button = 1'b1;
        tick();
        reset = 1'b1;
        check("mid_reset_empty", bus.empty, 1'b1);
        check("mid_reset_rd_data", bus.rd_data, 16'h0000);
        tick(12);
        check("no_stale_empty", bus.empty, 1'b1);
        check("no_stale_rd_data", bus.rd_data, 16'h0000);
        check("no_stale_ovf", bus.overflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/input_event_queue.md
Name: input_event_queue

Overview:
- Sits directly upstream of the CPU's memory-mapped I/O read path, replacing the level-only button/keyboard OR.
- Debounces the three active-low FPGA push buttons and converts each press into a one-shot PS/2-style scan code (28 left, 35 right, 41 shoot).
- Merges these codes with keyboard scan-code strobes into a first-word-fall-through (FWFT) FIFO.
- The CPU reads and pops events one at a time, so short presses are not missed between polls.

Parameters:
- WIDTH, 16, CPU data width; width of rd_data.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DB_CYCLES, 500000, consecutive stable cycles needed to accept a button change (10 ms at 50 MHz).
- LEFT_CODE, 28, code enqueued on a left press.
- RIGHT_CODE, 35, code enqueued on a right press.
- SHOOT_CODE, 41, code enqueued on a shoot press.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  synchronous, active-low reset.
- left_button  in  1  raw asynchronous button, active-low.
- right_button  in  1  raw asynchronous button, active-low.
- shoot_button  in  1  raw asynchronous button, active-low.
- kb_valid  in  1  one-cycle strobe; kb_code is valid.
- kb_code  in  8  keyboard scan code.
- rd_en  in  1  CPU pop strobe: an I/O-address read this cycle.
- clr_ovf  in  1  clears the overflow flag.
- rd_data  out  WIDTH  status word and head event.
- empty  out  1  FIFO has no entries.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky: a keyboard code was dropped.

Behaviour:
- Reset: single clock, synchronous, active-low. While reset=0 at a rising edge:
  - FIFO pointers and count go to 0.
  - Synchronizers and debounced levels go to 1 (released).
  - Debounce counters, pending flags and overflow go to 0.
  - Resulting outputs: empty=1, full=0, overflow=0, rd_data=0.
  - A reset in the middle of a press discards all pending and queued events.
- Synchronizer: each button passes through two flops (s1, s2) before any use.
- Debounce, per button:
  - The counter increments each cycle while s2 differs from the debounced level db.
  - The counter clears whenever s2 equals db.
  - When the counter equals DB_CYCLES-1 and s2 still differs from db, db takes s2 at that edge and the counter clears.
  - A bounce shorter than DB_CYCLES cycles never changes db.
- Press event:
  - A 1->0 transition of db sets that button's pending flag on the next edge.
  - Release (0->1) generates no event.
  - A pending flag stays set until its code is written into the FIFO.
- Held levels: held[2:0] = {~db_shoot, ~db_right, ~db_left}.
- Write arbitration, one FIFO write per cycle, priority kb_valid > left > right > shoot:
  - Keyboard: if FIFO is not full, or a pop occurs the same cycle, kb_code is written. Otherwise it is dropped and overflow is set.
  - Buttons: written only when no keyboard write happens that cycle and space exists (not full, or a pop occurs the same cycle). The written source's pending flag clears.
  - Buttons never drop; they wait while full.
- Pop:
  - rd_en with empty=0 advances the read pointer at the edge.
  - rd_en with empty=1 is ignored and does not corrupt the pointers.
- Simultaneous push and pop: both take effect and the count is unchanged. This applies even when full or when count=1.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- empty is (count==0); full is (count==DEPTH); both are registered-state derived and have no comb path from rd_en.
- rd_data is combinational from state (FWFT):
  - bit 15 = ~empty.
  - bits 14:12 = held[2:0].
  - bits 11:8 = 0.
  - bits 7:0 = head entry, or 0 when empty.
- Latency, keyboard: kb_valid at edge N makes rd_data[15]=1 after edge N (empty FIFO).
- Latency, button: with the raw button low and stable from just before edge 0:
  - db falls at edge DB_CYCLES+1.
  - pending sets at edge DB_CYCLES+2.
  - The entry is written at edge DB_CYCLES+3, when no keyboard write occurs.
- overflow: cleared by clr_ovf at the edge. If a drop and clr_ovf coincide, set wins.

Test Plan (DB_CYCLES=4, DEPTH=4):
- Reset, then idle: empty=1, full=0, overflow=0, rd_data=16'h0000; rd_en pulse -> still empty, pointers unchanged.
- left_button low and held -> rd_data becomes 16'h901C exactly after edge 7 (held bit 12 set, code 28). Pop -> rd_data=16'h1000 while held. Release -> rd_data=0 with no new event.
- shoot_button bounces low 3 cycles / high 2 cycles, repeated -> no event. Then low for 10 cycles -> exactly one entry, code 41 (16'hC029 while held).
- kb_valid with code 8'h1D on the same cycle left and right pending are ready -> FIFO order 29, 28, 35, written on 3 consecutive edges.
- Five kb_valid strobes with no pops -> full=1 after 4, overflow=1 on the 5th, head still first code. clr_ovf -> overflow=0. kb_valid plus rd_en while full -> count stays 4, new code at tail.
- Reset asserted with 3 entries queued and right pending -> empty=1 next cycle; after reset, no stale event appears.
